// File: rtl/vectorized_pe_stream_pkg.sv
// Shared opcode encoding and the per-lane arithmetic of the vectorised PE stream.
// Lane math runs at LANE_W bits on sign-extended operands; callers keep the low DWIDTH bits.
package pe_pkg;

    localparam int LANE_W  = 64;
    localparam int OP_W    = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_MIN  = 3'd3,
        OP_MAX  = 3'd4,
        OP_AND  = 3'd5,
        OP_PASS = 3'd6,
        OP_SWAP = 3'd7
    } pe_op_e;

    // Returns {o1, o2}; o2 always forwards operand A so PEs can be chained.
    function automatic logic [2*LANE_W-1:0] pe_lane_op(
        input pe_op_e            op,
        input logic [LANE_W-1:0] a,
        input logic [LANE_W-1:0] b
    );
        logic [LANE_W-1:0] o1;
        o1 = a;
        case (op)
            OP_ADD:  o1 = a + b;
            OP_SUB:  o1 = a - b;
            OP_MUL:  o1 = a * b;
            OP_MIN:  o1 = ($signed(a) < $signed(b)) ? a : b;
            OP_MAX:  o1 = ($signed(a) > $signed(b)) ? a : b;
            OP_AND:  o1 = a & b;
            OP_PASS: o1 = a;
            OP_SWAP: o1 = b;
        endcase
        return {o1, a};
    endfunction

endpackage

// File: rtl/stream_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered pointers.
// The extra pointer bit distinguishes full from empty when the address bits match.
module stream_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("stream_sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_wr   = wr_en_i && !full_o;
    assign do_rd   = rd_en_i && !empty_o;

    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/vectorized_pe_stream.sv
// SIMD processing element: joins two operand streams, applies one opcode to all lanes,
// delays the result through a fixed non-stalling pipeline and buffers it in a credited FIFO.
module vectorized_pe_stream
    import pe_pkg::*;
#(
    parameter int SIMD_DEGREE = 8,
    parameter int DWIDTH      = 32,
    parameter int LATENCY     = 3,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SIMD_DEGREE*DWIDTH-1:0] s1_tdata,
    input  logic [SIMD_DEGREE-1:0]        s1_tmask,
    input  logic                          s1_tvalid,
    input  logic [SIMD_DEGREE*DWIDTH-1:0] s2_tdata,
    input  logic [SIMD_DEGREE-1:0]        s2_tmask,
    input  logic                          s2_tvalid,
    input  logic [2:0]                    s_op,
    output logic                          s_tready,
    output logic [SIMD_DEGREE*DWIDTH-1:0] m1_tdata,
    output logic [SIMD_DEGREE*DWIDTH-1:0] m2_tdata,
    output logic [SIMD_DEGREE-1:0]        m_tmask,
    output logic                          m_tvalid,
    input  logic                          m_tready
);

    localparam int VW = SIMD_DEGREE * DWIDTH;
    localparam int FW = 2 * VW + SIMD_DEGREE;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    if (LATENCY < 1) begin : g_bad_latency
        $error("vectorized_pe_stream: LATENCY must be at least 1");
    end
    if (FIFO_DEPTH < LATENCY + 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("vectorized_pe_stream: FIFO_DEPTH must be a power of two and >= LATENCY+1");
    end
    if (DWIDTH < 1 || DWIDTH > LANE_W) begin : g_bad_width
        $error("vectorized_pe_stream: DWIDTH must be in 1..64");
    end

    logic          acc, pop;
    logic [CW-1:0] cred_q, cred_d;
    pe_op_e        op;

    logic [SIMD_DEGREE-1:0] lane_mask;
    logic [VW-1:0]          o1_lanes, o2_lanes;

    logic [LATENCY-1:0] stg_valid_q;
    logic [FW-1:0]      stg_data_q [LATENCY];

    logic [FW-1:0] fifo_rd_data;
    logic          fifo_full, fifo_empty;

    // Ready comes from registered credits only, so m_tready never reaches s_tready combinationally.
    assign s_tready = !rst && (cred_q < CW'(FIFO_DEPTH));
    assign acc      = s1_tvalid && s2_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;

    always_comb begin
        cred_d = cred_q;
        case ({acc, pop})
            2'b10:   cred_d = cred_q + 1'b1;
            2'b01:   cred_d = cred_q - 1'b1;
            default: cred_d = cred_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) cred_q <= '0;
        else     cred_q <= cred_d;
    end

    assign op        = pe_op_e'(s_op);
    assign lane_mask = (op == OP_PASS) ? s1_tmask : (s1_tmask & s2_tmask);

    for (genvar i = 0; i < SIMD_DEGREE; i++) begin : g_lane
        logic [LANE_W-1:0]   a_ext, b_ext;
        logic [2*LANE_W-1:0] res;

        assign a_ext = LANE_W'($signed(s1_tdata[i*DWIDTH +: DWIDTH]));
        assign b_ext = LANE_W'($signed(s2_tdata[i*DWIDTH +: DWIDTH]));
        assign res   = pe_lane_op(op, a_ext, b_ext);

        assign o1_lanes[i*DWIDTH +: DWIDTH] = lane_mask[i] ? res[LANE_W +: DWIDTH] : '0;
        assign o2_lanes[i*DWIDTH +: DWIDTH] = lane_mask[i] ? res[0 +: DWIDTH]      : '0;

        if (DWIDTH < LANE_W) begin : g_trim
            logic unused_hi;
            assign unused_hi = ^{res[2*LANE_W-1:LANE_W+DWIDTH], res[LANE_W-1:DWIDTH]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid_q <= '0;
        end else begin
            stg_valid_q[0] <= acc;
            for (int k = 1; k < LATENCY; k++) stg_valid_q[k] <= stg_valid_q[k-1];
        end
    end

    // Payload shifts unconditionally; the valid bits are what the reset clears.
    always_ff @(posedge clk) begin
        if (acc) stg_data_q[0] <= {lane_mask, o1_lanes, o2_lanes};
        for (int k = 1; k < LATENCY; k++) stg_data_q[k] <= stg_data_q[k-1];
    end

    stream_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (stg_valid_q[LATENCY-1]),
        .wr_data_i (stg_data_q[LATENCY-1]),
        .rd_en_i   (m_tready),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assert property (@(posedge clk) disable iff (rst) !(stg_valid_q[LATENCY-1] && fifo_full));

    assign m_tvalid = !fifo_empty;
    assign {m_tmask, m1_tdata, m2_tdata} = m_tvalid ? fifo_rd_data : '0;

endmodule

// File: doc/vectorized_pe_stream.md
# vectorized_pe_stream

Parametrised successor to the SIMD processing-element array: `SIMD_DEGREE` integer lanes share one per-beat opcode. Two operand streams are joined with a valid/ready handshake, then pass through a fixed-latency, non-stalling pipeline. A credit-counted output FIFO absorbs downstream backpressure. The block sits between CGRA switch ports, and its `o2` data forwards operand 1 so PEs can be chained systolically.

## Interface
Parameters:
- `SIMD_DEGREE`, 8: number of lanes.
- `DWIDTH`, 32: bits per lane.
- `LATENCY`, 3: pipeline stages, ≥1.
- `FIFO_DEPTH`, 8: output FIFO entries, power of two, ≥ `LATENCY`+1 (elaboration error otherwise).

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `s1_tdata`  in  SIMD_DEGREE*DWIDTH: operand A; lane i at bits [(i+1)*DWIDTH-1 : i*DWIDTH].
- `s1_tmask`  in  SIMD_DEGREE: per-lane valid for A.
- `s1_tvalid`  in  1: A beat valid.
- `s2_tdata`  in  SIMD_DEGREE*DWIDTH: operand B.
- `s2_tmask`  in  SIMD_DEGREE: per-lane valid for B.
- `s2_tvalid`  in  1: B beat valid.
- `s_op`  in  3: opcode, sampled with the beat.
- `s_tready`  out  1: shared ready for both input streams.
- `m1_tdata`  out  SIMD_DEGREE*DWIDTH: result.
- `m2_tdata`  out  SIMD_DEGREE*DWIDTH: forwarded operand.
- `m_tmask`  out  SIMD_DEGREE: per-lane result valid.
- `m_tvalid`  out  1: output beat valid.
- `m_tready`  in  1: downstream ready.

## Operation
- Accept: `acc = s1_tvalid & s2_tvalid & s_tready`. Both streams transfer together; neither is consumed alone.
- Per-lane ops, two's-complement `DWIDTH`, wrap-around:
  - 0 ADD: a+b
  - 1 SUB: a−b
  - 2 MUL: low `DWIDTH` bits of a*b
  - 3 MIN, signed
  - 4 MAX, signed
  - 5 AND
  - 6 PASS: o1=a
  - 7 SWAP: o1=b
- `m2` lane = a for ops 0–6, and a for SWAP as well.
- Lane mask = `s1_tmask & s2_tmask` for ops 0–5 and 7; `s1_tmask` for PASS. Masked-off lanes output 0 on both data buses.
- Pipeline: a valid bit plus data shift through `LATENCY` stages and never stall. The final stage writes the FIFO.
- Credit counter `cred` (0..`FIFO_DEPTH`) counts in-flight beats plus FIFO occupancy.
  - +1 on `acc`, −1 on pop (`m_tvalid & m_tready`). Both in the same cycle leaves it unchanged.
- `s_tready = !rst && (cred < FIFO_DEPTH)`, decoded from the registered `cred` only. There is no combinational path from `m_tready`, so a pop while full raises ready on the next cycle.
- FIFO is first-word-fall-through: `m_tvalid` = not empty. Data and mask buses read 0 while `m_tvalid`=0.
- Because credits cover every in-flight beat, a FIFO write can never occur while the FIFO is full. Verification treats this as an assertion.
- Reset mid-operation: all in-flight and buffered beats are discarded; none reach the output after reset.

## Timing
- Reset values: `s_tready`=0 while `rst`=1, then 1 on the first cycle after. `m_tvalid`=0, `m1_tdata`=`m2_tdata`=0, `m_tmask`=0. Pipeline valids, FIFO pointers and `cred` all clear to 0.
- Latency: a beat accepted at edge T is visible at the output (`m_tvalid`=1) in the cycle after edge T+`LATENCY`, provided the FIFO was empty. There are no bubbles under continuous valid/ready.
- Throughput: 1 beat per cycle while `m_tready`=1.
- Output obeys AXI-stream rules: data, mask and valid stay stable while `m_tvalid & !m_tready`.

## Structure
- Package `pe_pkg`:
  - `pe_op_e` enum, values 0–7.
  - Lane function `pe_lane_op(op, a, b)` returning {o1, o2}.
  - Shared constants.
- Sub-module `stream_sync_fifo` (parametrised width/depth, FWFT, registered pointers, full/empty flags).
  - Instantiated once, with width 2*SIMD_DEGREE*DWIDTH + SIMD_DEGREE.
- Top level holds the join, the credit counter, the generate-loop of lane ops and the delay pipeline.

## Test plan
- Reset then single ADD, lanes a=i+1, b=10, masks all-1 → after `LATENCY` cycles one beat: o1 lane i = i+11, o2 = a, mask 0xFF.
- SUB 0x00000000−1 and MUL 0x10000*0x10000 → 0xFFFFFFFF and 0x00000000. MIN/MAX of 0xFFFFFFFF vs 1 → 0xFFFFFFFF and 1 (signed compare).
- `s1_tmask`=0x0F, `s2_tmask`=0x3C, ADD → `m_tmask`=0x0C, other lanes 0. Same masks with PASS → mask 0x0F.
- `s1_tvalid`=1 with `s2_tvalid`=0 for 5 cycles → no accept and no output. Raising `s2_tvalid` → exactly one beat.
- `m_tready`=0, 20 back-to-back beats → exactly `FIFO_DEPTH`=8 accepted, `s_tready` drops. Release → 8 beats out in order, no loss or duplication, ready rises one cycle after the first pop.
- `rst` asserted with 2 beats in the pipeline and 3 in the FIFO → `m_tvalid`=0 after reset, and the next accepted beat is the first to emerge.
